// File: rtl/vga_store_queue.sv
// vga_store_queue: captures CPU stores into the framebuffer window and drains them one per fb handshake.
module vga_store_queue #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
  parameter int FB_PIXELS = 19200,
  parameter int FB_AW = 15,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic fb_valid,
  input  logic fb_ready,
  output logic [FB_AW-1:0] fb_addr,
  output logic [11:0] fb_data,
  output logic [$clog2(DEPTH):0] q_count,
  output logic overflow,
  input  logic clr_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [63:0] PIX = 64'(FB_PIXELS);
  logic we_d;
  logic [PW:0] wr_ptr, rd_ptr;
  logic [FB_AW+11:0] mem [DEPTH];
  logic [63:0] offset, idx;
  logic in_window, capture, empty, full, pop, push, drop;
  logic unused_ok;
  always_comb begin
    offset = cpu_addr - BASE_ADDR;
    idx = offset >> 2;
    in_window = (cpu_addr >= BASE_ADDR) && (idx < PIX);
    capture = cpu_we & ~we_d & in_window;
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    fb_valid = ~empty;
    pop = fb_valid & fb_ready;
    push = capture & (~full | pop);
    drop = capture & full & ~pop;
    fb_addr = mem[rd_ptr[PW-1:0]][FB_AW+11:12];
    fb_data = mem[rd_ptr[PW-1:0]][11:0];
    q_count = wr_ptr - rd_ptr;
    unused_ok = ^cpu_wdata[63:12];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_d <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      we_d <= cpu_we;
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= {idx[FB_AW-1:0], cpu_wdata[11:0]};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overflow <= drop | (overflow & ~clr_ovf);
    end
  end
endmodule
